// File: rtl/tdm_demux1x16.sv
// -----------------------------------------------------------------------------
// tdm_demux1x16
// Receive side of a 16-channel time-division multiplexed link. Locks onto the
// frame-sync marker, steers each accepted sample into a 16-slot shadow buffer
// and publishes the whole frame in parallel once its 16th sample arrives.
//
// Ports
//   clk        rising-edge clock, sole clock domain
//   rst        synchronous, active-high reset
//   in         multiplexed sample lane (WIDTH bits)
//   in_valid   'in' carries a sample this cycle
//   sync       marks the current sample as channel 0 (only with in_valid)
//   out        frame register, channel k at out[k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse: 'out' holds a new complete frame
//   sel        channel slot the next accepted sample will be written to
//   locked     high while the receiver is frame-locked (RUN)
//   err        one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tdm_demux1x16 #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  input  logic                  sync,
  output logic [16*WIDTH-1:0]   out,
  output logic                  out_valid,
  output logic [3:0]            sel,
  output logic                  locked,
  output logic                  err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          sel_r;
  logic [3:0]          sel_s;
  logic                wr_en_s;
  logic [3:0]          wr_idx_s;
  logic                frame_done_s;
  logic                err_s;
  logic [WIDTH-1:0]    shadow_r [16];
  logic [16*WIDTH-1:0] frame_s;
  logic [16*WIDTH-1:0] out_r;
  logic                out_valid_r;
  logic                err_r;

  // Next-state, slot steering and error decode for each accepted sample.
  always_comb begin
    state_s      = state_r;
    sel_s        = sel_r;
    wr_en_s      = 1'b0;
    wr_idx_s     = sel_r;
    frame_done_s = 1'b0;
    err_s        = 1'b0;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (sync) begin
            wr_en_s  = 1'b1;
            wr_idx_s = 4'd0;
            sel_s    = 4'd1;
            state_s  = RUN;
          end else begin
            // Unsynchronised samples are dropped while hunting.
            sel_s = 4'd0;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync always restarts the frame; away from slot 0 the
            // partial frame is abandoned and flagged.
            wr_en_s  = 1'b1;
            wr_idx_s = 4'd0;
            sel_s    = 4'd1;
            err_s    = (sel_r != 4'd0);
          end else if (sel_r == 4'd0) begin
            // Expected a sync marker here: lock is lost.
            err_s   = 1'b1;
            sel_s   = 4'd0;
            state_s = HUNT;
          end else begin
            wr_en_s      = 1'b1;
            wr_idx_s     = sel_r;
            sel_s        = sel_r + 4'd1;
            frame_done_s = (sel_r == 4'd15);
          end
        end
        default: begin
          state_s = HUNT;
          sel_s   = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Complete frame: slots 0..14 from the shadow buffer, slot 15 straight
  // from the lane so the frame can be published on the 16th sample's edge.
  always_comb begin
    frame_s = {(16*WIDTH){1'b0}};
    for (int k = 0; k < 15; k++) begin
      frame_s[k*WIDTH +: WIDTH] = shadow_r[k];
    end
    frame_s[15*WIDTH +: WIDTH] = in;
  end

  // Shadow buffer write; contents survive errors since every slot is
  // rewritten before the next publish.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      shadow_r[wr_idx_s] <= in;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      sel_r       <= 4'd0;
      out_r       <= {(16*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      out_valid_r <= frame_done_s;
      err_r       <= err_s;
      if (frame_done_s) begin
        out_r <= frame_s;
      end
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign sel       = sel_r;
  assign locked    = (state_r == RUN);
  assign err       = err_r;

endmodule

// File: tb/tb_tdm_demux1x16.sv
// Scoreboard bench for tdm_demux1x16 (WIDTH=4). Stimulus pushes hand-computed
// expected frames; a negedge monitor pops and compares on every out_valid.
module tb_tdm_demux1x16;

  localparam int W = 4;

  logic            clk;
  logic            rst;
  logic [W-1:0]    in;
  logic            in_valid;
  logic            sync;
  logic [16*W-1:0] out;
  logic            out_valid;
  logic [3:0]      sel;
  logic            locked;
  logic            err;

  int n_vec;
  int n_bad;
  int cyc;
  int ov_count;
  int err_count;
  int last_ov_cyc;
  int last_gap;
  logic [16*W-1:0] exp_q [$];

  tdm_demux1x16 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .sync     (sync),
    .out      (out),
    .out_valid(out_valid),
    .sel      (sel),
    .locked   (locked),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one sample for one clock; returns 1 time unit after the edge.
  task automatic send(input logic [W-1:0] d, input logic s);
    in = d; in_valid = 1'b1; sync = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; sync = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: cycle count, frame scoreboard, pulse bookkeeping.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid) begin
        ov_count++;
        last_gap    = cyc - last_ov_cyc;
        last_ov_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_out_valid: out=%h with no frame expected", out);
        end else begin
          chk("frame", out, exp_q.pop_front());
        end
        if (err) begin
          n_vec++; n_bad++;
          $display("FAIL err_with_out_valid: err=1 out_valid=1, expected not both");
        end
      end
      if (err) err_count++;
    end
  end

  int base;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; ov_count = 0; err_count = 0;
    last_ov_cyc = 0; last_gap = 0;
    rst = 1'b1; in = 4'h0; in_valid = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_out", out, 64'h0);
    chk("reset_ov", {63'd0, out_valid}, 64'd0);
    chk("reset_sel", {60'd0, sel}, 64'd0);
    chk("reset_locked", {63'd0, locked}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);

    // 1: back-to-back frames, ch k = k then ch k = 15-k.
    exp_q.push_back(64'hFEDCBA9876543210);
    for (int k = 0; k < 16; k++) send(4'(k), (k == 0));
    chk("t1_ov_latency", {63'd0, out_valid}, 64'd1);
    chk("t1_sel_wrap", {60'd0, sel}, 64'd0);
    chk("t1_locked", {63'd0, locked}, 64'd1);
    exp_q.push_back(64'h0123456789ABCDEF);
    for (int k = 0; k < 16; k++) send(4'(15 - k), (k == 0));
    idle(1);
    chk("t1_b2b_gap", 64'(last_gap), 64'd16);

    // 2: three frames with in_valid toggling every cycle.
    base = ov_count;
    exp_q.push_back(64'h0FEDCBA987654321);
    exp_q.push_back(64'h10FEDCBA98765432);
    exp_q.push_back(64'h210FEDCBA9876543);
    for (int f = 1; f <= 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        send(4'(k + f), (k == 0));
        if (f == 1 && k == 4) begin
          idle(1);
          chk("t2_sel_stall", {60'd0, sel}, 64'd5);
        end else begin
          idle(1);
        end
      end
    end
    idle(1);
    chk("t2_pulses", 64'(ov_count - base), 64'd3);
    chk("t2_gap", 64'(last_gap), 64'd32);

    // 3: hunt ignores unsynced samples, then locks on ch k = k+1.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 5; k++) send(4'hA, 1'b0);
    chk("t3_hunt_locked", {63'd0, locked}, 64'd0);
    chk("t3_hunt_sel", {60'd0, sel}, 64'd0);
    exp_q.push_back(64'h0FEDCBA987654321);
    for (int k = 0; k < 16; k++) send(4'(k + 1), (k == 0));
    chk("t3_ov", {63'd0, out_valid}, 64'd1);
    idle(2);

    // 4: early sync at sel=7 restarts the frame with ch k = 15-k.
    for (int k = 0; k < 7; k++) send(4'h5, (k == 0));
    chk("t4_sel7", {60'd0, sel}, 64'd7);
    send(4'hF, 1'b1);
    chk("t4_err", {63'd0, err}, 64'd1);
    chk("t4_no_ov", {63'd0, out_valid}, 64'd0);
    chk("t4_sel1", {60'd0, sel}, 64'd1);
    exp_q.push_back(64'h0123456789ABCDEF);
    for (int k = 1; k < 16; k++) send(4'(15 - k), 1'b0);
    chk("t4_err_clear", {63'd0, err}, 64'd0);
    chk("t4_ov", {63'd0, out_valid}, 64'd1);

    // 5: missing sync at slot 0 drops lock.
    send(4'h7, 1'b0);
    chk("t5_err", {63'd0, err}, 64'd1);
    chk("t5_locked", {63'd0, locked}, 64'd0);
    chk("t5_sel", {60'd0, sel}, 64'd0);
    chk("t5_out_hold", out, 64'h0123456789ABCDEF);
    idle(1);
    chk("t5_err_pulse", {63'd0, err}, 64'd0);
    chk("t5_err_count", 64'(err_count), 64'd2);

    // 6: reset mid-frame at sel=10, with a sample offered the same edge.
    for (int k = 0; k < 10; k++) send(4'h3, (k == 0));
    chk("t6_sel10", {60'd0, sel}, 64'd10);
    in = 4'h9; in_valid = 1'b1; sync = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_out", out, 64'h0);
    chk("t6_rst_sel", {60'd0, sel}, 64'd0);
    chk("t6_rst_locked", {63'd0, locked}, 64'd0);
    chk("t6_rst_ov", {63'd0, out_valid}, 64'd0);
    exp_q.push_back(64'hFEDCBA9876543210);
    for (int k = 0; k < 16; k++) send(4'(k), (k == 0));
    idle(3);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux1x16.md
# tdm_demux1x16

Time-division demultiplexer: the receive end of a 16-channel time-multiplexed link whose transmit side is our 16:1 mux tree. Accepts one sample per valid cycle on a single lane. Locks to a frame-sync marker and steers each sample into its channel slot. Presents all 16 channels in parallel once per complete frame. Sits between the serial link and the per-channel consumers.

## Interface
- WIDTH, 1, bits per channel sample (1..32)
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in  input  WIDTH  multiplexed sample lane
- in_valid  input  1  `in` carries a sample this cycle
- sync  input  1  qualifies the current sample as channel 0; meaningful only with in_valid
- out  output  16*WIDTH  frame register; channel k at out[k*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse: `out` updated with a new complete frame
- sel  output  4  channel index the next accepted sample will be written to
- locked  output  1  high in RUN state
- err  output  1  one-cycle pulse on framing error

## Operation
- Internal shadow buffer of 16 x WIDTH, written per sample; `out` is written only from a complete frame, never partially.
- Accepted sample = in_valid high at a rising clk edge. Cycles with in_valid low do nothing; sync ignored when in_valid low.
- States:
  - HUNT: sel held 0. Samples without sync discarded. in_valid & sync: write sample to shadow[0], sel<=1, go RUN.
  - RUN, sel!=0, no sync: write shadow[sel], sel<=sel+1 (wraps 15->0).
  - RUN, sel==15 accepted: the 16-slot frame (shadow[0..14] plus this sample) is copied to `out`, out_valid pulses, sel wraps to 0, stay RUN.
  - RUN, sel==0 with sync: normal frame start; write shadow[0], sel<=1.
  - RUN, sel==0 without sync: sync lost. err pulses, sample discarded, go HUNT, sel=0.
  - RUN, sel!=0 with sync (early sync): err pulses, partial frame abandoned (out unchanged, no out_valid), sample written to shadow[0], sel<=1, stay RUN.
- Shadow contents are not cleared on error; every slot is rewritten before the next copy to `out`.
- locked = (state==RUN).

## Timing
- Reset (rst high at an edge): out=0, out_valid=0, sel=0, locked=0, err=0, state HUNT. Reset overrides every other input in the same cycle, including mid-frame; partial frame lost, no out_valid.
- All outputs registered; no combinational path from inputs to outputs.
- Latency: out and out_valid reflect the 16th sample in the cycle after it is accepted (one clk). out holds value until the next complete frame.
- Minimum frame period 16 cycles with back-to-back in_valid; out_valid then pulses every 16 cycles with no gap.
- err asserted the cycle after the offending sample, high for exactly one cycle; err and out_valid never both high.
- Gaps in in_valid stretch the frame; no timeout.
- sel and locked change the cycle after the accepting edge.

## Test plan
- Reset, then 16 back-to-back samples, WIDTH=4, values 0x0..0xF, sync on first -> out_valid 1 cycle after the 16th, out = 0xFEDCBA9876543210, sel back to 0, locked=1.
- Three consecutive frames with in_valid toggling 1/0 each cycle -> exactly three out_valid pulses, one per 32 cycles; each out matches its frame; sel stalls on idle cycles.
- Five samples without sync after reset -> nothing written, locked=0, sel=0; then sync frame 0x1..0x10 -> captured correctly.
- In RUN, sync asserted at sel=7 -> err pulse, no out_valid, sel=1; following 15 samples complete a frame starting with the sync sample.
- In RUN, sample without sync at sel=0 -> err pulse, locked=0, sel=0, out keeps previous frame.
- rst asserted at sel=10 -> all outputs zero next cycle, state HUNT; a new synced frame completes normally.
